// File: rtl/light_pwm_ctrl_if.sv
// light_pwm_ctrl_if -- signal bundle between the light sensor front end and
// the PWM light controller.
//
// Handshake: sample_valid is a one-cycle strobe qualifying sample. There is
// no ready; the controller accepts every strobe in the cycle it is presented.
//
// Signals:
//   sample       8  light reading from the upstream sensor reader
//   sample_valid 1  one-cycle strobe, sample valid in that cycle
//   invert       1  1 = darker reading gives brighter output
//   pwm          1  registered PWM drive to the light
//   duty         8  duty currently applied
//   period_start 1  one-cycle pulse at the start of each PWM period
//   fault        1  high while the controller is in FAULT
//   state_dbg    2  current controller state (0 IDLE, 1 RUN, 2 FAULT)
//
// Modports: master drives readings (sensor side / bench), slave is the
// controller.
interface light_pwm_ctrl_if;
  logic [7:0] sample;
  logic       sample_valid;
  logic       invert;
  logic       pwm;
  logic [7:0] duty;
  logic       period_start;
  logic       fault;
  logic [1:0] state_dbg;

  modport master (
    output sample, sample_valid, invert,
    input  pwm, duty, period_start, fault, state_dbg
  );

  modport slave (
    input  sample, sample_valid, invert,
    output pwm, duty, period_start, fault, state_dbg
  );
endinterface

// File: rtl/light_pwm_ctrl.sv
// light_pwm_ctrl -- ambient-light driven PWM dimmer.
//
// Light readings are smoothed by a first-order IIR filter and mapped to a
// PWM duty (optionally inverted, clamped below at MIN_DUTY). The duty is
// only ever changed at the start of a PWM period so the output waveform
// never glitches mid-period. If readings stop arriving for TIMEOUT_PERIODS
// periods the controller falls back to FAILSAFE_DUTY and raises fault until
// the next reading.
//
// Ports:
//   clk  system clock, all logic on posedge
//   rst  synchronous, active-high reset
//   bus  light_pwm_ctrl_if.slave (sample/sample_valid/invert in,
//        pwm/duty/period_start/fault/state_dbg out)
//
// Parameters:
//   PRESCALE        clk cycles per PWM counter step (>=1)
//   FILT_SHIFT      IIR filter shift K (1..4)
//   MIN_DUTY        lowest duty applied in RUN
//   FAILSAFE_DUTY   duty applied in FAULT
//   TIMEOUT_PERIODS periods without a sample before FAULT (1..255)
module light_pwm_ctrl #(
  parameter int PRESCALE        = 4,
  parameter int FILT_SHIFT      = 2,
  parameter int MIN_DUTY        = 0,
  parameter int FAILSAFE_DUTY   = 128,
  parameter int TIMEOUT_PERIODS = 16
) (
  input logic              clk,
  input logic              rst,
  light_pwm_ctrl_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int AW = 8 + FILT_SHIFT;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]    CNT_LAST   = 8'd254;
  localparam logic [7:0]    MIN_D      = 8'(MIN_DUTY);
  localparam logic [7:0]    FAILSAFE_D = 8'(FAILSAFE_DUTY);
  localparam logic [7:0]    TO_LAST    = 8'(TIMEOUT_PERIODS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc;
  logic [7:0]    cnt;
  logic [7:0]    pcnt;
  logic [AW-1:0] acc;
  logic [7:0]    duty_q, duty_next;
  logic          pwm_q, period_start_q, fault_q;

  logic          tick;
  logic          wrap;
  logic [7:0]    filt;
  logic [7:0]    filt_dir;
  logic [7:0]    target;
  logic [AW-1:0] acc_filt;
  logic [AW-1:0] acc_preload;

  // Timebase: prescaler tick advances the 255-step PWM counter; the tick
  // that moves cnt from 254 back to 0 is the period boundary.
  assign tick = (presc == PRESC_LAST);
  assign wrap = tick && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= wrap ? 8'd0 : cnt + 8'd1;
    end
  end

  // IIR filter. acc holds the filtered value scaled by 2^K, so
  // acc - acc/2^K + sample never exceeds (255 << K).
  assign filt        = acc[AW-1 -: 8];
  assign acc_filt    = acc - (acc >> FILT_SHIFT) + AW'(bus.sample);
  assign acc_preload = {bus.sample, {FILT_SHIFT{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (bus.sample_valid) begin
      // Coming out of IDLE/FAULT the history is stale, so start fresh
      // from the new reading instead of slewing from an old value.
      acc <= (state == S_RUN) ? acc_filt : acc_preload;
    end
  end

  assign filt_dir = bus.invert ? (8'd255 - filt) : filt;
  assign target   = (filt_dir < MIN_D) ? MIN_D : filt_dir;

  // Periods elapsed in RUN since the last reading.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (bus.sample_valid) begin
      pcnt <= '0;
    end else if ((state == S_RUN) && wrap) begin
      pcnt <= pcnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and next duty. A reading always beats a timeout expiring
  // on the same edge. duty is decided from the state and acc as they stand
  // before the edge, so a reading arriving at a period boundary only shows
  // up one period later.
  always_comb begin
    state_next = state;
    duty_next  = duty_q;
    case (state)
      S_IDLE: begin
        if (bus.sample_valid) state_next = S_RUN;
        if (wrap)             duty_next  = 8'd0;
      end
      S_RUN: begin
        if (!bus.sample_valid && wrap && (pcnt == TO_LAST)) state_next = S_FAULT;
        if (wrap) duty_next = target;
      end
      S_FAULT: begin
        if (bus.sample_valid) state_next = S_RUN;
        if (wrap)             duty_next  = FAILSAFE_D;
      end
      default: begin
        state_next = S_IDLE;
        duty_next  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q         <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      duty_q         <= duty_next;
      pwm_q          <= (cnt < duty_q);
      period_start_q <= wrap;
      // Loaded from state_next so fault always matches the state register.
      fault_q        <= (state_next == S_FAULT);
    end
  end

  assign bus.pwm          = pwm_q;
  assign bus.duty         = duty_q;
  assign bus.period_start = period_start_q;
  assign bus.fault        = fault_q;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_light_pwm_ctrl.sv
// tb_light_pwm_ctrl -- bench for light_pwm_ctrl with a period-level reference
// model, an expected-response queue filled at each model period boundary and
// a negedge monitor that pops it whenever the DUT presents period_start.
module tb_light_pwm_ctrl;

  localparam int P   = 1;
  localparam int K   = 2;
  localparam int MIN = 0;
  localparam int FS  = 128;
  localparam int TO  = 4;
  localparam int PER = 255 * P;
  localparam int WATCHDOG = 80000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  light_pwm_ctrl_if bus ();

  light_pwm_ctrl #(
    .PRESCALE        (P),
    .FILT_SHIFT      (K),
    .MIN_DUTY        (MIN),
    .FAILSAFE_DUTY   (FS),
    .TIMEOUT_PERIODS (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 run, 2 fault. Period boundaries come from elapsed clock
  // count since reset release: every PER cycles a new period begins.
  int  m_e       = 0;
  int  m_mode    = 0;
  int  m_acc     = 0;
  int  m_periods = 0;
  int  m_duty    = 0;
  bit  rst_seen  = 1'b0;
  bit  m_wrap;
  logic [8:0] exp_q[$];   // {fault, duty} expected at each period_start

  function automatic int target_of(input int acc, input bit inv);
    int f, t;
    f = acc / (1 << K);
    t = inv ? 255 - f : f;
    if (t < MIN) t = MIN;
    return t;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_mode = 0; m_acc = 0; m_periods = 0; m_duty = 0; m_e = 0;
        rst_seen = 1'b1;
        exp_q.delete();
      end else begin
        rst_seen = 1'b0;
        m_wrap = ((m_e + 1) % PER) == 0;
        if (m_wrap) begin
          if (m_mode == 0)      m_duty = 0;
          else if (m_mode == 1) m_duty = target_of(m_acc, bus.invert);
          else                  m_duty = FS;
          if (m_mode == 1) m_periods++;
        end
        if (bus.sample_valid) begin
          if (m_mode == 1) m_acc = m_acc - m_acc / (1 << K) + int'(bus.sample);
          else             m_acc = int'(bus.sample) * (1 << K);
          m_mode = 1;
          m_periods = 0;
        end else if (m_wrap && m_mode == 1 && m_periods >= TO) begin
          m_mode = 2;
        end
        if (m_wrap) exp_q.push_back({(m_mode == 2), 8'(m_duty)});
        m_e++;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hi_cnt = 0;
  int prev_duty = 0;
  bit prev_valid = 1'b0;
  bit done = 1'b0;
  logic [8:0] exp_item;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_seen) begin
        chk("rst_pwm",          int'(bus.pwm),          0);
        chk("rst_duty",         int'(bus.duty),         0);
        chk("rst_period_start", int'(bus.period_start), 0);
        chk("rst_fault",        int'(bus.fault),        0);
        hi_cnt = 0;
        prev_valid = 1'b0;
      end else begin
        hi_cnt += int'(bus.pwm);
        if (bus.period_start === 1'b1 || exp_q.size() != 0) begin
          if (bus.period_start !== 1'b1) begin
            chk("period_start_missing", int'(bus.period_start), 1);
            void'(exp_q.pop_front());
            prev_valid = 1'b0;
          end else if (exp_q.size() == 0) begin
            chk("period_start_unexpected", int'(bus.period_start), 0);
            prev_valid = 1'b0;
          end else begin
            exp_item = exp_q.pop_front();
            chk("ps_duty",  int'(bus.duty),  int'(exp_item[7:0]));
            chk("ps_fault", int'(bus.fault), int'(exp_item[8]));
            if (prev_valid) chk("pwm_high_count", hi_cnt, prev_duty * P);
            prev_duty  = int'(exp_item[7:0]);
            prev_valid = 1'b1;
          end
          hi_cnt = 0;
        end
        chk("duty_hold",   int'(bus.duty),  m_duty);
        chk("fault_level", int'(bus.fault), (m_mode == 2) ? 1 : 0);
      end
      if (cyc > WATCHDOG) begin
        chk("watchdog_expired", cyc, WATCHDOG);
        done = 1'b1;
      end
      if (done) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int v);
    bus.sample       = 8'(v);
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns with the next posedge being a period boundary.
  task automatic align_wrap();
    int n;
    n = 0;
    while (((m_e + 1) % PER) != 0 && n < 2 * PER) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Returns with the next posedge being the boundary where RUN times out.
  task automatic align_expiry();
    int n;
    n = 0;
    while (!(((m_e + 1) % PER) == 0 && m_mode == 1 && m_periods == TO - 1) &&
           n < (TO + 2) * PER) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.sample       = 8'd0;
    bus.sample_valid = 1'b0;
    bus.invert       = 1'b0;
    rst              = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle: duty 0, no pwm pulses.
    idle(PER + 40);

    // Preload 200, then filter towards 0 (200 -> 150 -> 112).
    send(200);
    idle(2 * PER);
    send(0);
    idle(PER);
    send(0);
    idle(PER + 10);

    // Reset mid-period while duty is high.
    pulse_rst();
    send(200);
    idle(PER + 100);
    pulse_rst();
    idle(50);

    // Inverted mapping, both extremes.
    bus.invert = 1'b1;
    send(255);
    idle(2 * PER);
    pulse_rst();
    send(0);
    idle(2 * PER);

    // Timeout into FAULT, then recovery with a fresh reading.
    bus.invert = 1'b0;
    idle((TO + 2) * PER);
    send(50);
    idle(2 * PER);

    // Reading lands exactly on the timeout boundary: stays in RUN.
    align_expiry();
    send(77);
    idle(PER);

    // Reading lands exactly on a period boundary.
    align_wrap();
    send(10);
    idle(2 * PER);

    // Randomized readings, invert changes and gaps (some long enough to
    // time out, some aligned to period boundaries).
    for (int i = 0; i < 24; i++) begin
      bus.invert = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) align_wrap();
      send($urandom_range(0, 255));
      idle($urandom_range(1, (TO + 1) * PER));
    end

    idle(PER + 5);
    done = 1'b1;
  end

endmodule
